fetch_f1_f2: RTL and testbench
==============================

# fetch_f1_f2

Two-stage instruction fetch front end (F1 address issue, F2 instruction return) that produces the PC, PC+4, instruction and valid bit consumed by the F2→decode pipeline register. It owns the architectural fetch PC and sequential PC+4 advance. It handles stage stall and branch/jump redirect. It hides the one-cycle latency of a synchronous-read instruction memory, including stalls that would otherwise lose returned data.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] are 0.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  downstream not accepting; hold PC and all F2 outputs.
- redirect  in  1  taken branch/jump from a later stage; overrides stall.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored and forced to 0.
- imem_addr  out  32  instruction memory address, equal to the F1 PC register.
- imem_en  out  1  read enable; equals ~reset & ~stall.
- imem_rdata  in  32  read data, valid only in the cycle after a cycle with imem_en=1.
- PC_out_f2  out  32  PC of the instruction in F2.
- PC4_f2  out  32  PC_out_f2 + 4.
- instr_f2  out  32  instruction in F2; 32'h0 when valid_f2=0.
- valid_f2  out  1  F2 holds a real instruction.

## Operation
- State:
  - pc_f1: 32 bits.
  - pc_f2, pc4_f2: registered.
  - valid_f2.
  - fresh: imem_en was 1 last cycle.
  - hold_instr: 32 bits.
  - hold_vld.
- Reset values:
  - pc_f1=RESET_PC.
  - PC_out_f2=0, PC4_f2=0, valid_f2=0.
  - fresh=0, hold_vld=0, hold_instr=0.
  - instr_f2 therefore reads 0.
- Priority at each posedge: reset > redirect > stall > advance.
- Advance (no reset, redirect, or stall):
  - pc_f2←pc_f1 and pc4_f2←pc_f1+4.
  - valid_f2←1.
  - pc_f1←pc_f1+4.
  - hold_vld←0.
- Stall (no redirect):
  - pc_f1, pc_f2, pc4_f2 and valid_f2 hold.
  - If fresh=1 and hold_vld=0: hold_instr←imem_rdata and hold_vld←1.
- Redirect:
  - pc_f1←{redirect_pc[31:2],2'b00}.
  - valid_f2←0, hold_vld←0.
  - pc_f2 and pc4_f2 hold.
  - The in-flight memory response is discarded.
- fresh←imem_en every cycle; fresh←0 on reset.
- instr_f2 selection:
  - If valid_f2=0: 0.
  - Else if hold_vld=1: hold_instr.
  - Else: imem_rdata.
- Arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, no flag.

## Timing
- Fetch latency: the address is issued in cycle t with imem_en=1; the instruction appears on instr_f2 with valid_f2=1 in cycle t+1.
- Throughput: one instruction per cycle when stall=0.
- Redirect in cycle t (stall=0 in t+1):
  - t+1: bubble (valid_f2=0), imem_addr=target.
  - t+2: valid_f2=1, PC_out_f2=target.
  - Penalty: exactly one F2 bubble.
- Redirect and stall in the same cycle: redirect is taken. With stall held, pc_f1 keeps the target, valid_f2 stays 0 and no fetch is issued until stall falls.
- Stall across a fresh response:
  - The data is captured into hold_instr at the first stalled edge.
  - instr_f2 stays stable, bit-exact, for any stall length.
  - Release: the held instruction is consumed at the first non-stalled edge.
  - The next fetch, issued in the release cycle, returns the following cycle.
- Stall while valid_f2=0: bubble persists; nothing is captured.
- Output paths:
  - imem_addr is a register output.
  - imem_en is combinational from stall and reset.
  - instr_f2 is a mux from imem_rdata and hold_instr.
  - All other outputs are registers.
- Reset asserted mid-operation: the next edge applies reset values regardless of stall or redirect. imem_en=0 while reset=1.
- First cycle after reset deassert: imem_en=1, imem_addr=RESET_PC. One cycle later: valid_f2=1, PC_out_f2=RESET_PC, PC4_f2=RESET_PC+4.

## Test plan
- Reset release, RESET_PC=0, memory word n = 32'hA000_0000+n, no stall:
  - valid_f2 rises one cycle after deassert.
  - PC_out_f2 = 0, 4, 8, … with PC4_f2 = PC+4.
  - instr_f2 = A000_0000, A000_0001, … with no gaps.
- Stall for 3 cycles while F2 holds PC 8:
  - PC_out_f2=8, instr_f2=A000_0002 stable for all 3 cycles.
  - After release, next is PC 12, A000_0003, with no duplicate or drop.
- Redirect to 32'h0000_0103 while F2 holds PC 4:
  - Next cycle: valid_f2=0.
  - Following cycle: PC_out_f2=0x100, PC4_f2=0x104, instr from word 0x40.
- Redirect and stall asserted together, stall held 2 more cycles, target 0x200:
  - valid_f2=0 throughout the stall; imem_en=0.
  - After release: PC 0x200 appears one cycle later.
- Wrap: redirect to 32'hFFFF_FFF8:
  - PCs seen: FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - PC4_f2 for FFFF_FFFC is 0.
- Reset asserted during stall with hold_vld=1:
  - Next cycle: valid_f2=0, instr_f2=0, imem_en=0.
  - After release: fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_f1_f2_if.sv
// Fetch front-end bundle: control from later stages, instruction-memory port and
// F2 outputs. The fetch unit uses master; the pipeline/memory side uses slave.
interface fetch_f1_f2_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out_f2;
    logic [31:0] PC4_f2;
    logic [31:0] instr_f2;
    logic        valid_f2;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, imem_en, PC_out_f2, PC4_f2, instr_f2, valid_f2
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, imem_en, PC_out_f2, PC4_f2, instr_f2, valid_f2
    );
endinterface

// File: rtl/fetch_f1_f2.sv
// Two-stage fetch: F1 issues pc_f1 to a synchronous-read memory, F2 presents the
// returned instruction, with stall hold buffering and redirect handling.
module fetch_f1_f2 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_f1_f2_if.master bus
);
    logic [31:0] pc_f1;
    logic [31:0] pc_f2;
    logic [31:0] pc4_f2;
    logic [31:0] hold_instr;
    logic [31:0] instr_mux;
    logic        valid_f2;
    logic        fresh;
    logic        hold_vld;
    logic        imem_en;

    assign imem_en = ~reset & ~bus.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f1      <= RESET_PC;
            pc_f2      <= '0;
            pc4_f2     <= '0;
            valid_f2   <= 1'b0;
            fresh      <= 1'b0;
            hold_vld   <= 1'b0;
            hold_instr <= '0;
        end else begin
            fresh <= imem_en;
            if (bus.redirect) begin
                pc_f1    <= bus.redirect_pc & 32'hFFFF_FFFC;
                valid_f2 <= 1'b0;
                hold_vld <= 1'b0;
            end else if (bus.stall) begin
                // Memory output is only good the cycle after a read; park it once.
                if (fresh && valid_f2 && !hold_vld) begin
                    hold_instr <= bus.imem_rdata;
                    hold_vld   <= 1'b1;
                end
            end else begin
                pc_f2    <= pc_f1;
                pc4_f2   <= pc_f1 + 32'd4;
                valid_f2 <= 1'b1;
                pc_f1    <= pc_f1 + 32'd4;
                hold_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        instr_mux = '0;
        if (valid_f2) begin
            instr_mux = hold_vld ? hold_instr : bus.imem_rdata;
        end
    end

    assign bus.imem_addr = pc_f1;
    assign bus.imem_en   = imem_en;
    assign bus.PC_out_f2 = pc_f2;
    assign bus.PC4_f2    = pc4_f2;
    assign bus.instr_f2  = instr_mux;
    assign bus.valid_f2  = valid_f2;
endmodule

// File: tb/tb_fetch_f1_f2.sv
// Scoreboard bench for fetch_f1_f2: directed driver pushes expected F2 words,
// a negedge monitor checks/pops each word as it is presented and accepted.
module tb_fetch_f1_f2;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    logic   clk;
    logic   reset;
    int     n_cmp;
    int     n_bad;
    int     cyc;
    exp_t   q[$];

    fetch_f1_f2_if bus();

    fetch_f1_f2 #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] pc);
        return 32'hA000_0000 + {2'b00, pc[31:2]};
    endfunction

    // Memory returns garbage after a non-enabled cycle so stale data is visible.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.imem_en) bus.imem_rdata <= word(bus.imem_addr);
        else             bus.imem_rdata <= 32'h5BAD_0000 | cyc;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.instr = word(pc);
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        reset           = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        #1;
    endtask

    // Monitor: a valid word is compared every cycle; it is consumed when not stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.valid_f2) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        chk("pc_f2", bus.PC_out_f2, q[0].pc);
                        chk("pc4_f2", bus.PC4_f2, q[0].pc4);
                        chk("instr_f2", bus.instr_f2, q[0].instr);
                        if (!bus.stall) void'(q.pop_front());
                    end
                end else begin
                    chk("bubble_instr_zero", bus.instr_f2, 32'h0);
                end
            end
        end
    end

    initial begin
        #20000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rdata = '0;

        repeat (3) drive(1, 0, 0, 32'h0);
        chk("rst_valid", {31'd0, bus.valid_f2}, 32'd0);
        chk("rst_instr", bus.instr_f2, 32'h0);
        chk("rst_pc", bus.PC_out_f2, 32'h0);
        chk("rst_pc4", bus.PC4_f2, 32'h0);
        chk("rst_en", {31'd0, bus.imem_en}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);

        push(32'h0);        push(32'h4);        push(32'h8);
        push(32'hC);        push(32'h10);       push(32'h100);
        push(32'h104);      push(32'h200);      push(32'h204);
        push(32'hFFFF_FFF8); push(32'hFFFF_FFFC); push(32'h0);
        push(32'h4);        // killed by reset while stalled

        drive(0, 0, 0, 32'h0);                       // R0
        chk("first_en", {31'd0, bus.imem_en}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        drive(0, 0, 0, 32'h0);                       // R1: F2=0
        drive(0, 0, 0, 32'h0);                       // R2: F2=4
        repeat (3) drive(0, 1, 0, 32'h0);            // R3-R5: stall with F2=8
        drive(0, 0, 0, 32'h0);                       // R6: release, 8 consumed
        drive(0, 0, 0, 32'h0);                       // R7: F2=C
        drive(0, 0, 1, 32'h0000_0103);               // R8: F2=10, redirect
        drive(0, 0, 0, 32'h0);                       // R9: bubble
        chk("redir_bubble", {31'd0, bus.valid_f2}, 32'd0);
        chk("redir_addr", bus.imem_addr, 32'h100);
        drive(0, 0, 0, 32'h0);                       // R10: F2=100
        drive(0, 0, 1, 32'h0000_0300);               // R11: F2=104, redirect
        drive(0, 1, 1, 32'h0000_0200);               // R12: redirect + stall
        repeat (2) begin                             // R13-R14
            drive(0, 1, 0, 32'h0);
            chk("rs_valid", {31'd0, bus.valid_f2}, 32'd0);
            chk("rs_en", {31'd0, bus.imem_en}, 32'd0);
            chk("rs_addr", bus.imem_addr, 32'h200);
        end
        drive(0, 0, 0, 32'h0);                       // R15: release
        chk("rs_rel_en", {31'd0, bus.imem_en}, 32'd1);
        chk("rs_rel_valid", {31'd0, bus.valid_f2}, 32'd0);
        drive(0, 0, 0, 32'h0);                       // R16: F2=200
        drive(0, 0, 1, 32'hFFFF_FFF8);               // R17: F2=204, redirect
        repeat (4) drive(0, 0, 0, 32'h0);            // R18-R21: bubble, F8, FC, 0
        drive(0, 1, 0, 32'h0);                       // R22: stall with F2=4
        drive(1, 1, 0, 32'h0);                       // R23: reset during stall
        drive(1, 0, 0, 32'h0);                       // R24
        if (q.size() != 0) void'(q.pop_front());
        chk("rst2_valid", {31'd0, bus.valid_f2}, 32'd0);
        chk("rst2_instr", bus.instr_f2, 32'h0);
        chk("rst2_en", {31'd0, bus.imem_en}, 32'd0);
        push(32'h0); push(32'h4); push(32'h8);
        drive(0, 0, 0, 32'h0);                       // R25
        chk("restart_addr", bus.imem_addr, 32'h0);
        repeat (3) drive(0, 0, 0, 32'h0);            // R26-R28
        drive(1, 0, 0, 32'h0);                       // R29
        drive(1, 0, 0, 32'h0);                       // R30
        chk("queue_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
